// File: rtl/writeback_arbiter_if.sv
// Writeback bundle: pipeline results, long-latency valid/ready channel, register-file write port and hazard mask.
// master = producers / hazard logic side, slave = the arbiter.
interface writeback_arbiter_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
);
  logic                   pipe_valid;
  logic [4:0]             pipe_rd;
  logic [XLEN-1:0]        pipe_data;
  logic                   lu_valid;
  logic                   lu_ready;
  logic [4:0]             lu_rd;
  logic [XLEN-1:0]        lu_data;
  logic                   we3;
  logic [4:0]             wa3;
  logic [XLEN-1:0]        wd3;
  logic [31:0]            pend_mask;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   pipe_stall;

  modport master (
    output pipe_valid, pipe_rd, pipe_data, lu_valid, lu_rd, lu_data,
    input  lu_ready, we3, wa3, wd3, pend_mask, fifo_count, pipe_stall
  );

  modport slave (
    input  pipe_valid, pipe_rd, pipe_data, lu_valid, lu_rd, lu_data,
    output lu_ready, we3, wa3, wd3, pend_mask, fifo_count, pipe_stall
  );
endinterface

// File: rtl/writeback_arbiter.sv
// Merges pipeline and long-latency results onto one registered RF write port (1 cycle); pipeline never stalls,
// long-latency side queues in a DEPTH-entry FIFO behind lu_ready. Optional starvation guard: WB_STARVE_GUARD_EN.
module writeback_arbiter #(
  parameter int XLEN         = 32,
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                reset,
  writeback_arbiter_if.slave  wb
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [4:0]      rd_q   [DEPTH];
  logic [XLEN-1:0] data_q [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [PW-1:0]   head_q, tail_q;
  logic [CW-1:0]   cnt_q;
  logic            we3_q;
  logic [4:0]      wa3_q;
  logic [XLEN-1:0] wd3_q;
  logic            pipe_win, pop, push, lu_ready;
  logic [31:0]     pend;

  // Writes to x0 are discarded on both sides and never claim the port.
  assign pipe_win = wb.pipe_valid && (wb.pipe_rd != 5'd0);
  assign pop      = !pipe_win && (cnt_q != '0);
  assign lu_ready = reset && (cnt_q < CW'(DEPTH));
  assign push     = wb.lu_valid && lu_ready && (wb.lu_rd != 5'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      vld_q  <= '0;
      we3_q  <= 1'b0;
      wa3_q  <= 5'd0;
      wd3_q  <= '0;
    end else begin
      if (push) begin
        vld_q[tail_q] <= 1'b1;
        tail_q        <= tail_q + PW'(1);
      end
      if (pop) begin
        vld_q[head_q] <= 1'b0;
        head_q        <= head_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
      we3_q <= pipe_win || pop;
      if (pipe_win) begin
        wa3_q <= wb.pipe_rd;
        wd3_q <= wb.pipe_data;
      end else if (pop) begin
        wa3_q <= rd_q[head_q];
        wd3_q <= data_q[head_q];
      end
    end
  end

  // Payload needs no reset: an entry is only observed while its valid bit is set.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_q[tail_q]   <= wb.lu_rd;
      data_q[tail_q] <= wb.lu_data;
    end
  end

  always_comb begin
    pend = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i]) pend[rd_q[i]] = 1'b1;
    end
  end

`ifdef WB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] starve_q;
  logic          stall_q;

  // Counts edges the queued head loses to the pipeline; fires a one-cycle stall request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_q <= '0;
      stall_q  <= 1'b0;
    end else begin
      stall_q <= 1'b0;
      if (pop || cnt_q == '0) begin
        starve_q <= '0;
      end else if (pipe_win) begin
        if (starve_q == SW'(STARVE_LIMIT - 1)) begin
          starve_q <= '0;
          stall_q  <= 1'b1;
        end else begin
          starve_q <= starve_q + SW'(1);
        end
      end
    end
  end
  assign wb.pipe_stall = stall_q;
`else
  wire unused_starve_limit = (STARVE_LIMIT != 0);
  assign wb.pipe_stall = 1'b0;
`endif

  assign wb.lu_ready   = lu_ready;
  assign wb.we3        = we3_q;
  assign wb.wa3        = wa3_q;
  assign wb.wd3        = wd3_q;
  assign wb.pend_mask  = pend;
  assign wb.fifo_count = cnt_q;
endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter (DEPTH=2, STARVE_LIMIT=4); expectations are hand-computed per step.
module tb_writeback_arbiter;
`ifdef WB_STARVE_GUARD_EN
  localparam logic GUARD = 1'b1;
`else
  localparam logic GUARD = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  writeback_arbiter_if #(.XLEN(32), .DEPTH(2)) wb ();
  writeback_arbiter #(.XLEN(32), .DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .wb    (wb.slave)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_wb(input string tag, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic [1:0] cnt, input logic [31:0] pm, input logic rdy, input logic stall);
    chk({tag, ".we3"}, 64'(wb.we3), 64'(we));
    chk({tag, ".wa3"}, 64'(wb.wa3), 64'(wa));
    chk({tag, ".wd3"}, 64'(wb.wd3), 64'(wd));
    chk({tag, ".fifo_count"}, 64'(wb.fifo_count), 64'(cnt));
    chk({tag, ".pend_mask"}, 64'(wb.pend_mask), 64'(pm));
    chk({tag, ".lu_ready"}, 64'(wb.lu_ready), 64'(rdy));
    chk({tag, ".pipe_stall"}, 64'(wb.pipe_stall), 64'(stall));
  endtask

  task automatic set_pipe(input logic v, input logic [4:0] rd, input logic [31:0] d);
    wb.pipe_valid = v;
    wb.pipe_rd    = rd;
    wb.pipe_data  = d;
  endtask

  task automatic set_lu(input logic v, input logic [4:0] rd, input logic [31:0] d);
    wb.lu_valid = v;
    wb.lu_rd    = rd;
    wb.lu_data  = d;
  endtask

  initial begin
    set_pipe(1'b0, 5'd0, 32'h0);
    set_lu(1'b0, 5'd0, 32'h0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_wb("reset", 1'b0, 5'd0, 32'h0, 2'd0, 32'h0, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    chk("release.lu_ready", 64'(wb.lu_ready), 64'd1);

    // Single pipeline write, then idle
    set_pipe(1'b1, 5'd5, 32'hDEADBEEF);
    tick;
    chk_wb("pipe5", 1'b1, 5'd5, 32'hDEADBEEF, 2'd0, 32'h0, 1'b1, 1'b0);
    set_pipe(1'b0, 5'd0, 32'h0);
    tick;
    chk_wb("pipe_idle", 1'b0, 5'd5, 32'hDEADBEEF, 2'd0, 32'h0, 1'b1, 1'b0);

    // Fill FIFO behind a busy pipeline
    set_pipe(1'b1, 5'd1, 32'hA1);
    set_lu(1'b1, 5'd3, 32'h11);
    tick;
    chk_wb("fill1", 1'b1, 5'd1, 32'hA1, 2'd1, 32'h8, 1'b1, 1'b0);
    set_pipe(1'b1, 5'd2, 32'hA2);
    set_lu(1'b1, 5'd7, 32'h22);
    tick;
    chk_wb("fill2", 1'b1, 5'd2, 32'hA2, 2'd2, 32'h88, 1'b0, 1'b0);

    // Full FIFO: pipeline wins, lu offer not accepted
    set_pipe(1'b1, 5'd9, 32'h99);
    set_lu(1'b1, 5'd12, 32'h33);
    tick;
    chk_wb("full_pipe9", 1'b1, 5'd9, 32'h99, 2'd2, 32'h88, 1'b0, 1'b0);

    // Drain in order
    set_pipe(1'b0, 5'd0, 32'h0);
    set_lu(1'b0, 5'd0, 32'h0);
    tick;
    chk_wb("drain_rd3", 1'b1, 5'd3, 32'h11, 2'd1, 32'h80, 1'b1, 1'b0);
    tick;
    chk_wb("drain_rd7", 1'b1, 5'd7, 32'h22, 2'd0, 32'h0, 1'b1, 1'b0);
    tick;
    chk_wb("drain_done", 1'b0, 5'd7, 32'h22, 2'd0, 32'h0, 1'b1, 1'b0);

    // Push and pop on the same edge
    set_lu(1'b1, 5'd4, 32'h44);
    tick;
    chk_wb("pp_push4", 1'b0, 5'd7, 32'h22, 2'd1, 32'h10, 1'b1, 1'b0);
    set_lu(1'b1, 5'd6, 32'h66);
    tick;
    chk_wb("pp_both", 1'b1, 5'd4, 32'h44, 2'd1, 32'h40, 1'b1, 1'b0);
    set_lu(1'b0, 5'd0, 32'h0);
    tick;
    chk_wb("pp_pop6", 1'b1, 5'd6, 32'h66, 2'd0, 32'h0, 1'b1, 1'b0);
    tick;
    chk_wb("pp_idle", 1'b0, 5'd6, 32'h66, 2'd0, 32'h0, 1'b1, 1'b0);

    // x0 destinations on both sides are dropped
    set_pipe(1'b1, 5'd0, 32'hBAD);
    set_lu(1'b1, 5'd0, 32'hBAD);
    tick;
    chk_wb("x0_both", 1'b0, 5'd6, 32'h66, 2'd0, 32'h0, 1'b1, 1'b0);

    // Pipeline write to x0 lets the FIFO pop
    set_pipe(1'b0, 5'd0, 32'h0);
    set_lu(1'b1, 5'd10, 32'hAA);
    tick;
    chk_wb("x0_q10", 1'b0, 5'd6, 32'h66, 2'd1, 32'h400, 1'b1, 1'b0);
    set_pipe(1'b1, 5'd0, 32'hBAD);
    set_lu(1'b0, 5'd0, 32'h0);
    tick;
    chk_wb("x0_pop10", 1'b1, 5'd10, 32'hAA, 2'd0, 32'h0, 1'b1, 1'b0);
    set_pipe(1'b0, 5'd0, 32'h0);
    tick;
    chk_wb("x0_idle", 1'b0, 5'd10, 32'hAA, 2'd0, 32'h0, 1'b1, 1'b0);

    // Starvation: head loses 4 consecutive edges to the pipeline
    set_pipe(1'b1, 5'd21, 32'hC0);
    set_lu(1'b1, 5'd20, 32'h55);
    tick;
    chk_wb("starve_q", 1'b1, 5'd21, 32'hC0, 2'd1, 32'h0010_0000, 1'b1, 1'b0);
    set_lu(1'b0, 5'd0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk_wb($sformatf("starve_win%0d", i), 1'b1, 5'd21, 32'hC0, 2'd1, 32'h0010_0000, 1'b1, 1'b0);
    end
    tick;
    chk_wb("starve_fire", 1'b1, 5'd21, 32'hC0, 2'd1, 32'h0010_0000, 1'b1, GUARD);
    set_pipe(1'b0, 5'd0, 32'h0);
    tick;
    chk_wb("starve_pop20", 1'b1, 5'd20, 32'h55, 2'd0, 32'h0, 1'b1, 1'b0);

    // Reset mid-drain discards queued entries
    set_pipe(1'b1, 5'd11, 32'hB1);
    set_lu(1'b1, 5'd13, 32'h13);
    tick;
    chk_wb("rst_fill1", 1'b1, 5'd11, 32'hB1, 2'd1, 32'h2000, 1'b1, 1'b0);
    set_pipe(1'b1, 5'd12, 32'hB2);
    set_lu(1'b1, 5'd14, 32'h14);
    tick;
    chk_wb("rst_fill2", 1'b1, 5'd12, 32'hB2, 2'd2, 32'h6000, 1'b0, 1'b0);
    set_pipe(1'b0, 5'd0, 32'h0);
    set_lu(1'b0, 5'd0, 32'h0);
    tick;
    chk_wb("rst_drain", 1'b1, 5'd13, 32'h13, 2'd1, 32'h4000, 1'b1, 1'b0);
    reset = 1'b0;
    #1;
    chk_wb("rst_async", 1'b0, 5'd0, 32'h0, 2'd0, 32'h0, 1'b0, 1'b0);
    tick;
    chk_wb("rst_held", 1'b0, 5'd0, 32'h0, 2'd0, 32'h0, 1'b0, 1'b0);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk_wb($sformatf("rst_after%0d", i), 1'b0, 5'd0, 32'h0, 2'd0, 32'h0, 1'b1, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
